// File: rtl/miner_result_tx_if.sv
// ============================================================================
// miner_result_tx_if : result handshake + UART byte-strobe bundle
// Revision : 1.0
// ============================================================================
`default_nettype none

interface miner_result_tx_if;
    logic        result_valid;
    logic        result_ready;
    logic [7:0]  result_job;
    logic [31:0] result_nonce;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        is_transmitting;

    modport master (
        input  result_valid, result_job, result_nonce, is_transmitting,
        output result_ready, transmit, tx_byte
    );

    modport slave (
        output result_valid, result_job, result_nonce, is_transmitting,
        input  result_ready, transmit, tx_byte
    );
endinterface

`default_nettype wire

// File: rtl/miner_result_tx.sv
// ============================================================================
// miner_result_tx : frames a mining result (sync, job, nonce) to a byte UART
// Option  : RESULT_TX_CHECKSUM_EN appends an XOR checksum byte
// Revision : 1.0
// ============================================================================
`default_nettype none

module miner_result_tx #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  wire logic         clk_hf,
    input  wire logic         reset,
    miner_result_tx_if.master bus,
    output logic              busy,
    output logic [15:0]       frame_count,
    output logic              ack_error
);

`ifdef RESULT_TX_CHECKSUM_EN
    localparam int unsigned c_FRAME_LEN = 7;
`else
    localparam int unsigned c_FRAME_LEN = 6;
`endif
    localparam logic [2:0]  c_LAST_IDX  = 3'(c_FRAME_LEN - 1);
    localparam int unsigned c_TMR_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_GAP       = 3'd1;
    localparam logic [2:0] c_STROBE    = 3'd2;
    localparam logic [2:0] c_WAIT_ACK  = 3'd3;
    localparam logic [2:0] c_WAIT_DONE = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         r_idx;
    logic [c_TMR_W-1:0] r_timer;
    logic [7:0]         r_job;
    logic [31:0]        r_nonce;
    logic [7:0]         r_tx_byte;
    logic [15:0]        r_frame_count;
    logic               r_ack_error;

    logic [2:0]         w_load_idx;
    logic [7:0]         w_load_byte;
    logic               w_capture;

    assign w_capture         = (r_state == c_IDLE) && bus.result_valid;
    assign bus.result_ready  = (r_state == c_IDLE);
    // Gating on is_transmitting guarantees no strobe lands on a busy UART.
    assign bus.transmit      = (r_state == c_STROBE) && !bus.is_transmitting;
    assign bus.tx_byte       = r_tx_byte;
    assign busy              = (r_state != c_IDLE);
    assign frame_count       = r_frame_count;
    assign ack_error         = r_ack_error;

    // Index of the byte to load into tx_byte on the next transition into GAP.
    always_comb begin
        w_load_idx = r_idx;
        if (r_state == c_IDLE) begin
            w_load_idx = 3'd0;
        end else if (r_state == c_WAIT_DONE) begin
            w_load_idx = r_idx + 3'd1;
        end
    end

    always_comb begin
        w_load_byte = SYNC_BYTE;
        case (w_load_idx)
            3'd0:    w_load_byte = SYNC_BYTE;
            3'd1:    w_load_byte = r_job;
            3'd2:    w_load_byte = r_nonce[31:24];
            3'd3:    w_load_byte = r_nonce[23:16];
            3'd4:    w_load_byte = r_nonce[15:8];
            3'd5:    w_load_byte = r_nonce[7:0];
`ifdef RESULT_TX_CHECKSUM_EN
            3'd6:    w_load_byte = r_job ^ r_nonce[31:24] ^ r_nonce[23:16]
                                 ^ r_nonce[15:8] ^ r_nonce[7:0];
`endif
            default: w_load_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk_hf or posedge reset) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_idx         <= 3'd0;
            r_timer       <= '0;
            r_job         <= 8'h00;
            r_nonce       <= 32'h0;
            r_tx_byte     <= 8'h00;
            r_frame_count <= 16'h0;
            r_ack_error   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_capture) begin
                        r_job     <= bus.result_job;
                        r_nonce   <= bus.result_nonce;
                        r_idx     <= 3'd0;
                        r_tx_byte <= w_load_byte;
                        r_state   <= c_GAP;
                    end
                end
                c_GAP: begin
                    if (!bus.is_transmitting) begin
                        r_state <= c_STROBE;
                    end
                end
                c_STROBE: begin
                    r_timer <= '0;
                    r_state <= bus.is_transmitting ? c_GAP : c_WAIT_ACK;
                end
                c_WAIT_ACK: begin
                    if (bus.is_transmitting) begin
                        r_state <= c_WAIT_DONE;
                    end else if (r_timer == c_TMR_LAST) begin
                        // UART never picked the byte up: flag it and resend.
                        r_ack_error <= 1'b1;
                        r_timer     <= '0;
                        r_tx_byte   <= w_load_byte;
                        r_state     <= c_GAP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_WAIT_DONE: begin
                    if (!bus.is_transmitting) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_idx         <= 3'd0;
                            r_frame_count <= r_frame_count + 16'd1;
                            r_state       <= c_IDLE;
                        end else begin
                            r_idx     <= w_load_idx;
                            r_tx_byte <= w_load_byte;
                            r_state   <= c_GAP;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_miner_result_tx.sv
// ============================================================================
// tb_miner_result_tx : randomized self-checking bench with a UART model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_miner_result_tx;

`ifdef RESULT_TX_CHECKSUM_EN
    localparam int FLEN = 7;
`else
    localparam int FLEN = 6;
`endif

    logic        clk_hf = 1'b0;
    logic        reset  = 1'b1;
    logic        busy;
    logic [15:0] frame_count;
    logic        ack_error;

    miner_result_tx_if bus ();

    miner_result_tx dut (
        .clk_hf      (clk_hf),
        .reset       (reset),
        .bus         (bus.master),
        .busy        (busy),
        .frame_count (frame_count),
        .ack_error   (ack_error)
    );

    always #5 clk_hf = ~clk_hf;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int          pulse_cnt = 0;
    int          first_pulse_cyc = 0;
    int          last_pulse_cyc  = 0;
    int          ack_dly  = 3;
    int          busy_len = 10;
    bit          noack    = 1'b0;
    bit          hold     = 1'b0;
    bit          model_clr = 1'b0;
    int          cap_cyc;
    logic [15:0] cap_fc;

    always @(posedge clk_hf) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // UART model: records acknowledged bytes, rises ack_dly cycles after a strobe.
    initial begin
        int  dly;
        int  bcnt;
        bit  uart_busy;
        logic [7:0] last_byte;
        dly = 0; bcnt = 0; uart_busy = 1'b0; last_byte = 8'h00;
        bus.is_transmitting = 1'b0;
        forever begin
            @(negedge clk_hf);
            if (bus.transmit) begin
                chk("strobe_while_busy", {31'd0, bus.is_transmitting}, 32'd0);
                if (pulse_cnt == 0) first_pulse_cyc = cyc;
                last_pulse_cyc = cyc;
                pulse_cnt++;
                if (!noack && !model_clr) begin
                    rx_q.push_back(bus.tx_byte);
                    last_byte = bus.tx_byte;
                    dly = ack_dly;
                end
            end else if (model_clr) begin
                uart_busy = 1'b0; dly = 0; bcnt = 0;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin uart_busy = 1'b1; bcnt = busy_len; end
            end else if (uart_busy) begin
                bcnt--;
                if (bcnt == 0) begin
                    chk("tx_byte_hold", {24'd0, bus.tx_byte}, {24'd0, last_byte});
                    uart_busy = 1'b0;
                end
            end
            bus.is_transmitting = uart_busy | hold;
        end
    end

    task automatic add_exp(input logic [7:0] j, input logic [31:0] n);
        exp_q.push_back(8'hA5);
        exp_q.push_back(j);
        for (int k = 3; k >= 0; k--) exp_q.push_back(n[8*k +: 8]);
        if (FLEN == 7) exp_q.push_back(j ^ n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0]);
    endtask

    task automatic offer(input logic [7:0] j, input logic [31:0] n);
        bit got = 1'b0;
        @(negedge clk_hf);
        bus.result_valid = 1'b1;
        bus.result_job   = j;
        bus.result_nonce = n;
        for (int i = 0; i < 3000 && !got; i++) begin
            chk("ready_vs_busy", {31'd0, bus.result_ready}, {31'd0, !busy});
            if (bus.result_ready) begin
                @(posedge clk_hf); #1;
                got = 1'b1; cap_cyc = cyc; cap_fc = frame_count;
            end else begin
                @(negedge clk_hf);
            end
        end
        if (!got) chk("offer_timeout", 32'd0, 32'd1);
        bus.result_valid = 1'b0;
        bus.result_job   = 8'($urandom);
        bus.result_nonce = $urandom;
        add_exp(j, n);
    endtask

    task automatic wait_fc(input logic [15:0] target, input int budget);
        for (int i = 0; i < budget && frame_count != target; i++) @(negedge clk_hf);
        if (frame_count != target) chk("frame_wait_timeout", {16'd0, frame_count}, {16'd0, target});
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk_hf);
        if (rx_q.size() < n) chk("rx_wait_timeout", rx_q.size(), n);
    endtask

    task automatic cmp_frames(input string tag);
        chk({tag, "_len"}, rx_q.size(), exp_q.size());
        foreach (exp_q[i])
            chk(tag, (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] base;
        int          rise;
        bus.result_valid = 1'b0;
        bus.result_job   = 8'h00;
        bus.result_nonce = 32'h0;

        repeat (3) @(negedge clk_hf);
        chk("rst_ready",  {31'd0, bus.result_ready}, 32'd1);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_tx",     {31'd0, bus.transmit}, 32'd0);
        chk("rst_byte",   {24'd0, bus.tx_byte}, 32'd0);
        chk("rst_fc",     {16'd0, frame_count}, 32'd0);
        chk("rst_ackerr", {31'd0, ack_error}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_hf);

        // Reference frame with 3-cycle ack, 10-cycle byte time.
        pulse_cnt = 0;
        offer(8'h01, 32'h1234_5678);
        wait_fc(16'd1, 3000);
        // Capture edge opens GAP; the strobe is the following cycle.
        chk("first_pulse_lat", first_pulse_cyc - cap_cyc, 1);
        chk("ref_pulses", pulse_cnt, FLEN);
        chk("ref_fc", {16'd0, frame_count}, 32'd1);
        cmp_frames("ref_byte");

        for (int t = 0; t < 6; t++) begin
            ack_dly  = $urandom_range(1, 5);
            busy_len = $urandom_range(1, 12);
            repeat ($urandom_range(0, 4)) @(negedge clk_hf);
            pulse_cnt = 0;
            base = frame_count;
            offer(8'($urandom), $urandom);
            wait_fc(base + 16'd1, 3000);
            chk("rnd_pulses", pulse_cnt, FLEN);
            cmp_frames("rnd_byte");
        end

        // Back-to-back results: second one held off until the first frame ends.
        ack_dly = 3; busy_len = 10;
        base = frame_count;
        offer(8'h5C, $urandom);
        wait_rx(3, 3000);
        offer(8'hC3, $urandom);
        chk("b_after_a", {16'd0, cap_fc}, {16'd0, base + 16'd1});
        wait_fc(base + 16'd2, 3000);
        cmp_frames("b2b_byte");

        // UART already busy at capture.
        @(posedge clk_hf); #1 hold = 1'b1;
        pulse_cnt = 0;
        base = frame_count;
        offer(8'h77, $urandom);
        repeat (20) @(negedge clk_hf);
        chk("hold_no_pulse", pulse_cnt, 0);
        chk("hold_busy", {31'd0, busy}, 32'd1);
        @(posedge clk_hf); #1 hold = 1'b0;
        rise = cyc;
        for (int i = 0; i < 10 && pulse_cnt == 0; i++) @(negedge clk_hf);
        chk("hold_release_lat", (last_pulse_cyc - rise) <= 1, 1);
        wait_fc(base + 16'd1, 3000);
        cmp_frames("hold_byte");

        // UART ignores strobes until the ack timeout fires.
        noack = 1'b1;
        pulse_cnt = 0;
        base = frame_count;
        offer(8'h3E, $urandom);
        repeat (200) @(negedge clk_hf);
        chk("ackerr_early", {31'd0, ack_error}, 32'd0);
        for (int i = 0; i < 300 && !ack_error; i++) @(negedge clk_hf);
        rise = cyc;
        noack = 1'b0;
        chk("ackerr_set", {31'd0, ack_error}, 32'd1);
        // 255 cycles in WAIT_ACK after the strobe cycle, then flagged.
        chk("ackerr_time", rise - first_pulse_cyc, 256);
        wait_fc(base + 16'd1, 3000);
        chk("resend_pulses", pulse_cnt > FLEN, 1);
        chk("ackerr_sticky", {31'd0, ack_error}, 32'd1);
        cmp_frames("resend_byte");

        // Asynchronous reset in the middle of a frame.
        offer(8'h99, $urandom);
        wait_rx(2, 3000);
        @(posedge clk_hf); #3;
        reset = 1'b1; model_clr = 1'b1;
        #1;
        chk("abort_tx",     {31'd0, bus.transmit}, 32'd0);
        chk("abort_busy",   {31'd0, busy}, 32'd0);
        chk("abort_ready",  {31'd0, bus.result_ready}, 32'd1);
        chk("abort_fc",     {16'd0, frame_count}, 32'd0);
        chk("abort_ackerr", {31'd0, ack_error}, 32'd0);
        pulse_cnt = 0;
        repeat (5) @(negedge clk_hf);
        chk("abort_no_pulse", pulse_cnt, 0);
        reset = 1'b0; model_clr = 1'b0;
        rx_q.delete(); exp_q.delete();
        repeat (15) @(negedge clk_hf);
        offer(8'h42, $urandom);
        wait_fc(16'd1, 3000);
        cmp_frames("post_rst_byte");

        // Counter wrap.
        @(negedge clk_hf);
        force dut.r_frame_count = 16'hFFFF;
        @(posedge clk_hf); #1;
        release dut.r_frame_count;
        chk("fc_preset", {16'd0, frame_count}, 32'h0000_FFFF);
        offer(8'hEE, $urandom);
        wait_fc(16'd0, 3000);
        chk("fc_wrap", {16'd0, frame_count}, 32'd0);
        cmp_frames("wrap_byte");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
